// File: rtl/bd_funnel_decoder.sv
// BD funnel decoder: strips the route prefix, identifies the leaf, reassembles two-flit leaf-2 words.
// Optional feature macro: BD_DECODE_ERR_EN (counts dropped 1111 flits on err_count).
module bd_funnel_decoder #(
    parameter int FLIT_W    = 21,
    parameter int LEAF_W    = 2,
    parameter int PAYLOAD_W = 36
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [FLIT_W-1:0]    bd_data_in_d,
    input  logic                 bd_data_in_v,
    output logic                 bd_data_in_a,
    output logic [LEAF_W-1:0]    words_out_leaf,
    output logic [PAYLOAD_W-1:0] words_out_payload,
    output logic                 words_out_v,
    input  logic                 words_out_a,
    output logic [15:0]          err_count
);
    typedef enum logic {IDLE, HALF} state_t;

    state_t                 state_q;
    logic [17:0]            acc_q;
    logic                   out_v_q;
    logic [LEAF_W-1:0]      leaf_q;
    logic [PAYLOAD_W-1:0]   pay_q;

    logic [3:0]             pfx;
    logic                   in_acc;
    logic                   dec_emit;
    logic                   dec_l2;
    logic [LEAF_W-1:0]      dec_leaf;
    logic [PAYLOAD_W-1:0]   dec_pay;

    assign pfx = bd_data_in_d[FLIT_W-1 -: 4];

    // Single output register: a new flit can land whenever the current word leaves this cycle.
    assign bd_data_in_a = reset || !out_v_q || words_out_a;
    assign in_acc       = bd_data_in_v && bd_data_in_a && !reset;

    always_comb begin
        dec_emit = 1'b0;
        dec_l2   = 1'b0;
        dec_leaf = '0;
        dec_pay  = '0;
        casez (pfx)
            4'b0???: begin
                dec_emit = 1'b1;
                dec_leaf = LEAF_W'(0);
                dec_pay  = PAYLOAD_W'(bd_data_in_d[19:0]);
            end
            4'b10??: begin
                dec_emit = 1'b1;
                dec_leaf = LEAF_W'(1);
                dec_pay  = PAYLOAD_W'(bd_data_in_d[18:0]);
            end
            4'b110?: begin
                dec_l2   = 1'b1;
                dec_emit = (state_q == HALF);
                dec_leaf = LEAF_W'(2);
                dec_pay  = PAYLOAD_W'({bd_data_in_d[17:0], acc_q});
            end
            4'b1110: begin
                dec_emit = 1'b1;
                dec_leaf = LEAF_W'(3);
                dec_pay  = PAYLOAD_W'(bd_data_in_d[16:0]);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            out_v_q <= 1'b0;
            leaf_q  <= '0;
            pay_q   <= '0;
        end else begin
            if (words_out_a) begin
                out_v_q <= 1'b0;
            end
            if (in_acc) begin
                if (dec_emit) begin
                    out_v_q <= 1'b1;
                    leaf_q  <= dec_leaf;
                    pay_q   <= dec_pay;
                end
                // Other leaves may interleave with a pending leaf-2 half; only leaf-2 flits touch acc/state.
                if (dec_l2) begin
                    if (state_q == IDLE) begin
                        acc_q   <= bd_data_in_d[17:0];
                        state_q <= HALF;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            end
        end
    end

    assign words_out_v       = out_v_q;
    assign words_out_leaf    = leaf_q;
    assign words_out_payload = pay_q;

`ifdef BD_DECODE_ERR_EN
    logic [15:0] err_q;
    logic        bad;

    assign bad = (pfx == 4'b1111);

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= '0;
        end else if (in_acc && bad && err_q != 16'hFFFF) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_bd_funnel_decoder.sv
// Bench for bd_funnel_decoder: directed scenarios plus random flits/backpressure against a word-level scoreboard.
module tb_bd_funnel_decoder;
    logic        clk = 1'b0;
    logic        reset;
    logic [20:0] bd_data_in_d;
    logic        bd_data_in_v;
    logic        bd_data_in_a;
    logic [1:0]  words_out_leaf;
    logic [35:0] words_out_payload;
    logic        words_out_v;
    logic        words_out_a;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    bd_funnel_decoder dut (
        .clk               (clk),
        .reset             (reset),
        .bd_data_in_d      (bd_data_in_d),
        .bd_data_in_v      (bd_data_in_v),
        .bd_data_in_a      (bd_data_in_a),
        .words_out_leaf    (words_out_leaf),
        .words_out_payload (words_out_payload),
        .words_out_v       (words_out_v),
        .words_out_a       (words_out_a),
        .err_count         (err_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: expected words in order, plus leaf-2 half-word and error tally.
    int              q_leaf[$];
    longint unsigned q_pay[$];
    bit              m_half;
    longint unsigned m_acc;
    int              m_err;
    bit              took;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_err();
`ifdef BD_DECODE_ERR_EN
        return (m_err > 65535) ? 64'd65535 : 64'(m_err);
`else
        return 64'd0;
`endif
    endfunction

    // Prefix classes are contiguous numeric ranges of the 21-bit flit.
    task automatic model_flit(input logic [20:0] f);
        longint unsigned v = longint'(f);
        if (v < 64'h100000) begin
            q_leaf.push_back(0); q_pay.push_back(v);
        end else if (v < 64'h180000) begin
            q_leaf.push_back(1); q_pay.push_back(v - 64'h100000);
        end else if (v < 64'h1C0000) begin
            if (!m_half) begin
                m_acc  = v - 64'h180000;
                m_half = 1'b1;
            end else begin
                q_leaf.push_back(2);
                q_pay.push_back((v - 64'h180000) * 64'd262144 + m_acc);
                m_half = 1'b0;
            end
        end else if (v < 64'h1E0000) begin
            q_leaf.push_back(3); q_pay.push_back(v - 64'h1C0000);
        end else begin
            m_err++;
        end
    endtask

    task automatic step(input logic rst_v, input logic v, input logic [20:0] d, input logic a,
                        output bit acc);
        acc = 1'b0;
        @(negedge clk);
        check_eq("out_v", words_out_v, q_leaf.size() != 0);
        if (q_leaf.size() != 0) begin
            check_eq("out_leaf", words_out_leaf, q_leaf[0]);
            check_eq("out_payload", words_out_payload, q_pay[0]);
        end
        check_eq("err_count", err_count, exp_err());
        reset        = rst_v;
        bd_data_in_v = v;
        bd_data_in_d = d;
        words_out_a  = a;
        #1;
        check_eq("in_a", bd_data_in_a, rst_v || !words_out_v || a);
        if (rst_v) begin
            q_leaf.delete();
            q_pay.delete();
            m_half = 1'b0;
            m_acc  = 0;
            m_err  = 0;
        end else begin
            if (words_out_v && a && q_leaf.size() != 0) begin
                void'(q_leaf.pop_front());
                void'(q_pay.pop_front());
            end
            if (v && bd_data_in_a) begin
                acc = 1'b1;
                model_flit(d);
            end
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 21'h0ABCDE, 1'b0, took);
        step(1'b1, 1'b1, 21'h1B0001, 1'b1, took);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [20:0] rand_flit();
        logic [20:0] r = 21'($urandom);
        case ($urandom_range(0, 9))
            0, 1:    return {1'b0, r[19:0]};
            2, 3:    return {2'b10, r[18:0]};
            4, 5, 6: return {3'b110, r[17:0]};
            7, 8:    return {4'b1110, r[16:0]};
            default: return {4'b1111, r[16:0]};
        endcase
    endfunction

    initial begin
        reset = 1'b1; bd_data_in_v = 1'b0; bd_data_in_d = '0; words_out_a = 1'b0;
        m_half = 1'b0; m_acc = 0; m_err = 0;
        repeat (2) @(posedge clk);

        do_reset();
        settle();
        check_eq("rst_v", words_out_v, 0);
        check_eq("rst_leaf", words_out_leaf, 0);
        check_eq("rst_payload", words_out_payload, 0);
        check_eq("rst_err", err_count, 0);

        // Leaf 0 single flit
        step(1'b0, 1'b1, 21'h0ABCDE, 1'b1, took);
        settle();
        check_eq("t1_v", words_out_v, 1);
        check_eq("t1_leaf", words_out_leaf, 0);
        check_eq("t1_payload", words_out_payload, 36'h0000ABCDE);
        step(1'b0, 1'b0, 21'h0, 1'b1, took);
        settle();
        check_eq("t1_one_word", words_out_v, 0);

        // Leaf 2 pair
        do_reset();
        step(1'b0, 1'b1, 21'h1B0001, 1'b1, took);
        settle();
        check_eq("t2_half_no_out", words_out_v, 0);
        step(1'b0, 1'b1, 21'h1A0002, 1'b1, took);
        settle();
        check_eq("t2_v", words_out_v, 1);
        check_eq("t2_leaf", words_out_leaf, 2);
        check_eq("t2_payload", words_out_payload, 36'h8000B0001);
        step(1'b0, 1'b0, 21'h0, 1'b1, took);

        // Leaf 1 interleaved inside a leaf 2 pair
        do_reset();
        step(1'b0, 1'b1, 21'h1B0001, 1'b1, took);
        step(1'b0, 1'b1, 21'h100005, 1'b1, took);
        settle();
        check_eq("t3_leaf1", words_out_leaf, 1);
        check_eq("t3_pay1", words_out_payload, 36'h5);
        step(1'b0, 1'b1, 21'h1A0002, 1'b1, took);
        settle();
        check_eq("t3_leaf2", words_out_leaf, 2);
        check_eq("t3_pay2", words_out_payload, 36'h8000B0001);
        step(1'b0, 1'b0, 21'h0, 1'b1, took);

        // Sink stall with input pending
        do_reset();
        step(1'b0, 1'b1, 21'h0ABCDE, 1'b0, took);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 21'h012345, 1'b0, took);
            check_eq("t4_in_a_low", bd_data_in_a, 0);
            check_eq("t4_not_taken", took, 0);
        end
        check_eq("t4_hold_pay", words_out_payload, 36'h0ABCDE);
        step(1'b0, 1'b1, 21'h012345, 1'b1, took);
        check_eq("t4_taken", took, 1);
        step(1'b0, 1'b0, 21'h0, 1'b1, took);
        step(1'b0, 1'b0, 21'h0, 1'b1, took);

        // Invalid flits
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 21'h1FFFFF, 1'b1, took);
        settle();
        check_eq("t5_no_out", words_out_v, 0);
`ifdef BD_DECODE_ERR_EN
        check_eq("t5_err", err_count, 3);
`else
        check_eq("t5_err", err_count, 0);
`endif

        // Reset while HALF
        do_reset();
        step(1'b0, 1'b1, 21'h1B0001, 1'b1, took);
        do_reset();
        step(1'b0, 1'b1, 21'h1A0002, 1'b1, took);
        settle();
        check_eq("t6_no_out", words_out_v, 0);
        step(1'b0, 1'b1, 21'h1B0001, 1'b1, took);
        settle();
        check_eq("t6_v", words_out_v, 1);
        check_eq("t6_payload", words_out_payload, 36'hC00060002);
        step(1'b0, 1'b0, 21'h0, 1'b1, took);

        // Random traffic with source/sink backpressure
        do_reset();
        begin
            int          flits = 0;
            int          cyc   = 0;
            logic        v     = 1'b0;
            logic [20:0] d     = '0;
            while (flits < 10000 && cyc < 60000) begin
                if (!v || took) begin
                    v = ($urandom_range(0, 3) != 0);
                    d = rand_flit();
                end
                step(1'b0, v, d, ($urandom_range(0, 3) != 0), took);
                if (took) flits++;
                cyc++;
            end
            check_eq("rand_timeout", cyc < 60000, 1);
            for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 21'h0, 1'b1, took);
            check_eq("drain_empty", q_leaf.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
